// File: rtl/fps_meter_pkg.sv
// Shared definitions for the fps_meter event-rate meter.
// Contents: period FSM state encoding, saturating increment, counter width helper.
package fps_meter_pkg;

   // Period FSM states
   localparam logic [0:0] ST_WAIT_FIRST = 1'b0;
   localparam logic [0:0] ST_MEASURING  = 1'b1;

   // Increment that sticks at lim instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
      return (val >= lim) ? lim : val + 32'd1;
   endfunction

   // Bits needed to hold the values 0..n-1 (at least 1)
   function automatic int unsigned cnt_bits(input int unsigned n);
      int unsigned w;
      w = 1;
      while (((n - 1) >> w) != 0) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/fps_meter_ch.sv
// One measured channel of fps_meter: synchroniser, edge detector, running
// counter with per-gate latch, probe toggle and (with FPS_METER_PERIOD_EN)
// an edge-to-edge period FSM.
// Ports:
//   clk_i, rst_ni   measurement clock, async active-low reset
//   gate_end_i      terminal gate cycle (already suppressed by clear)
//   clear_i         synchronous restart of running count and period FSM
//   evt_i           asynchronous event strobe
//   count_o         edges counted in the last completed gate window
//   toggle_o        flips on every detected edge
//   period_o        last edge-to-edge period in clocks (0 without the macro)
module fps_meter_ch
   import fps_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        EDGE_FALL   = 1'b0,
   parameter int unsigned PER_W       = 28
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             gate_end_i,
   input  logic             clear_i,
   input  logic             evt_i,
   output logic [CNT_W-1:0] count_o,
   output logic             toggle_o,
   output logic [PER_W-1:0] period_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   det_q;
   logic                   sync_last_c;
   logic                   edge_c;
   logic [CNT_W-1:0]       run_q, run_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       run_inc_c;
   logic [CNT_W-1:0]       total_c;
   logic                   tog_q;

   // Synchroniser chain followed by the edge-detector history flop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         det_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], evt_i};
         det_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_last_c = sync_q[SYNC_STAGES-1];
   assign edge_c      = EDGE_FALL ? (det_q & ~sync_last_c) : (sync_last_c & ~det_q);

   // Running count including this cycle's edge, saturating
   assign run_inc_c = CNT_W'(sat_inc(32'(run_q), 32'(CNT_MAX)));
   assign total_c   = edge_c ? run_inc_c : run_q;

   // Counting and latching; an edge in the terminal cycle closes the old window
   always_comb begin
      run_d   = run_q;
      count_d = count_q;
      if (clear_i) begin
         run_d = '0;
      end else if (gate_end_i) begin
         count_d = total_c;
         run_d   = '0;
      end else begin
         run_d = total_c;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q   <= '0;
         count_q <= '0;
         tog_q   <= 1'b0;
      end else begin
         run_q   <= run_d;
         count_q <= count_d;
         tog_q   <= tog_q ^ edge_c;
      end
   end

   assign count_o  = count_q;
   assign toggle_o = tog_q;

`ifdef FPS_METER_PERIOD_EN
   localparam logic [PER_W-1:0] PER_MAX = '1;

   logic [0:0]       state_q, state_d;
   logic [PER_W-1:0] stamp_q, stamp_d;
   logic [PER_W-1:0] period_q, period_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_WAIT_FIRST;
         stamp_q  <= '0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         stamp_q  <= stamp_d;
         period_q <= period_d;
      end
   end

   // Stamp starts at 1 on an edge so the next edge reads the full spacing
   always_comb begin
      state_d  = state_q;
      stamp_d  = stamp_q;
      period_d = period_q;
      case (state_q)
         ST_WAIT_FIRST: begin
            if (edge_c) begin
               stamp_d = PER_W'(1);
               state_d = ST_MEASURING;
            end
         end
         ST_MEASURING: begin
            if (edge_c) begin
               period_d = stamp_q;
               stamp_d  = PER_W'(1);
            end else begin
               stamp_d = PER_W'(sat_inc(32'(stamp_q), 32'(PER_MAX)));
            end
         end
      endcase
      if (clear_i) begin
         state_d = ST_WAIT_FIRST;
         stamp_d = '0;
      end
   end

   assign period_o = period_q;
`else
   assign period_o = '0;
`endif

endmodule

// File: rtl/fps_meter.sv
// Multi-channel event-rate meter: counts edges on N_CH asynchronous strobes
// over a GATE_CYCLES window of I_clk and latches frames-per-gate.
// Optional macro FPS_METER_PERIOD_EN adds per-channel edge-to-edge period.
// Ports:
//   I_clk        measurement clock (all logic in this domain)
//   I_rst_n      asynchronous active-low reset
//   I_clear      synchronous restart of gate and running counts
//   I_evt        N_CH asynchronous event strobes
//   O_count      latched count per channel, ch i at [i*CNT_W +: CNT_W]
//   O_valid      one-cycle pulse when O_count updates
//   O_toggle     per-channel probe, flips on each detected edge
//   O_heartbeat  flips at every gate end
//   O_period     last edge-to-edge period per channel (0 without the macro)
module fps_meter
   import fps_meter_pkg::*;
#(
   parameter int unsigned     N_CH        = 4,
   parameter int unsigned     GATE_CYCLES = 27_000_000,
   parameter int unsigned     CNT_W       = 16,
   parameter int unsigned     SYNC_STAGES = 2,
   parameter logic [N_CH-1:0] EDGE_SEL    = '0,
   parameter int unsigned     PER_W       = 28
) (
   input  logic                    I_clk,
   input  logic                    I_rst_n,
   input  logic                    I_clear,
   input  logic [N_CH-1:0]         I_evt,
   output logic [N_CH*CNT_W-1:0]   O_count,
   output logic                    O_valid,
   output logic [N_CH-1:0]         O_toggle,
   output logic                    O_heartbeat,
   output logic [N_CH*PER_W-1:0]   O_period
);

   localparam int unsigned       GATE_W    = cnt_bits(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   logic [GATE_W-1:0] gate_q, gate_d;
   logic              gate_end_c;
   logic              valid_q, valid_d;
   logic              hb_q, hb_d;

   // Clear in the terminal cycle suppresses the latch entirely
   assign gate_end_c = (gate_q == GATE_LAST) && !I_clear;

   // Gate counter, valid pulse and heartbeat
   always_comb begin
      gate_d  = gate_q + GATE_W'(1);
      valid_d = gate_end_c;
      hb_d    = hb_q ^ gate_end_c;
      if (I_clear || gate_end_c) gate_d = '0;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         gate_q  <= '0;
         valid_q <= 1'b0;
         hb_q    <= 1'b0;
      end else begin
         gate_q  <= gate_d;
         valid_q <= valid_d;
         hb_q    <= hb_d;
      end
   end

   assign O_valid     = valid_q;
   assign O_heartbeat = hb_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      fps_meter_ch #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_FALL   (EDGE_SEL[i]),
         .PER_W       (PER_W)
      ) u_ch (
         .clk_i      (I_clk),
         .rst_ni     (I_rst_n),
         .gate_end_i (gate_end_c),
         .clear_i    (I_clear),
         .evt_i      (I_evt[i]),
         .count_o    (O_count[i*CNT_W +: CNT_W]),
         .toggle_o   (O_toggle[i]),
         .period_o   (O_period[i*PER_W +: PER_W])
      );
   end

endmodule

// File: tb/tb_fps_meter.sv
// Bench for fps_meter: two instances (CNT_W=8 and CNT_W=4) share stimulus;
// a window-level model predicts every output each cycle, and directed
// scenarios pin specific values by hand.
module tb_fps_meter;

   localparam int unsigned GATE  = 100;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned PER_W = 12;
   localparam int          PMAX  = 4095;
   localparam logic [3:0]  EDGE_SEL = 4'b0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic [3:0]  evt;

   logic [31:0] cnt8;
   logic [15:0] cnt4;
   logic        valid8, valid4, hb8, hb4;
   logic [3:0]  tog8, tog4;
   logic [47:0] per8, per4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fps_meter #(.N_CH(4), .GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(SYNC),
               .EDGE_SEL(EDGE_SEL), .PER_W(PER_W)) u_dut (
      .I_clk(clk), .I_rst_n(rst_n), .I_clear(clear), .I_evt(evt),
      .O_count(cnt8), .O_valid(valid8), .O_toggle(tog8),
      .O_heartbeat(hb8), .O_period(per8));

   fps_meter #(.N_CH(4), .GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(SYNC),
               .EDGE_SEL(EDGE_SEL), .PER_W(PER_W)) u_dut4 (
      .I_clk(clk), .I_rst_n(rst_n), .I_clear(clear), .I_evt(evt),
      .O_count(cnt4), .O_valid(valid4), .O_toggle(tog4),
      .O_heartbeat(hb4), .O_period(per4));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   // ---------------- model: window totals from sampled input history -------
   int         m_gcnt;
   int         m_run [4];
   int         m_cnt [4];
   int         m_per [4];
   logic       m_valid, m_hb;
   logic [3:0] m_tog;
   logic [3:0] hist [0:SYNC];
`ifdef FPS_METER_PERIOD_EN
   int         m_meas [4];
   int         m_stamp [4];
`endif

   task automatic m_reset();
      m_gcnt  = 0;
      m_valid = 1'b0;
      m_hb    = 1'b0;
      m_tog   = '0;
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      for (int i = 0; i < 4; i++) begin
         m_run[i] = 0;
         m_cnt[i] = 0;
         m_per[i] = 0;
`ifdef FPS_METER_PERIOD_EN
         m_meas[i]  = 0;
         m_stamp[i] = 0;
`endif
      end
   endtask

   task automatic m_step();
      logic [3:0] e;
      // Edge seen by the logic now is between the samples SYNC and SYNC+1 clocks old
      e = (~EDGE_SEL & hist[SYNC-1] & ~hist[SYNC]) | (EDGE_SEL & ~hist[SYNC-1] & hist[SYNC]);
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = evt;
      m_tog   = m_tog ^ e;
      m_valid = 1'b0;
      if (clear) begin
         m_gcnt = 0;
         for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
`ifdef FPS_METER_PERIOD_EN
            m_meas[i]  = 0;
            m_stamp[i] = 0;
`endif
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (e[i]) m_run[i]++;
`ifdef FPS_METER_PERIOD_EN
            if (m_meas[i] == 0) begin
               if (e[i]) begin m_stamp[i] = 1; m_meas[i] = 1; end
            end else if (e[i]) begin
               m_per[i]   = m_stamp[i];
               m_stamp[i] = 1;
            end else if (m_stamp[i] < PMAX) begin
               m_stamp[i]++;
            end
`endif
         end
         if (m_gcnt == int'(GATE) - 1) begin
            for (int i = 0; i < 4; i++) begin
               m_cnt[i] = m_run[i];
               m_run[i] = 0;
            end
            m_valid = 1'b1;
            m_hb    = ~m_hb;
            m_gcnt  = 0;
         end else begin
            m_gcnt++;
         end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else        m_step();
      end
   end

   // ---------------- per-cycle compare against the model -------------------
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("count8[%0d]", i), 64'(cnt8[i*8 +: 8]), 64'(sat(m_cnt[i], 255)));
            chk($sformatf("count4[%0d]", i), 64'(cnt4[i*4 +: 4]), 64'(sat(m_cnt[i], 15)));
            chk($sformatf("period8[%0d]", i), 64'(per8[i*12 +: 12]), 64'(m_per[i]));
            chk($sformatf("period4[%0d]", i), 64'(per4[i*12 +: 12]), 64'(m_per[i]));
         end
         chk("valid8", 64'(valid8), 64'(m_valid));
         chk("valid4", 64'(valid4), 64'(m_valid));
         chk("toggle8", 64'(tog8), 64'(m_tog));
         chk("toggle4", 64'(tog4), 64'(m_tog));
         chk("heartbeat8", 64'(hb8), 64'(m_hb));
         chk("heartbeat4", 64'(hb4), 64'(m_hb));
      end
   end

   // ---------------- directed scenarios -------------------------------------
   task automatic wait_gcnt(input int g);
      int k;
      k = 0;
      while (m_gcnt != g && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) chk("gate_wait_timeout", 64'(k), 64'(0));
   endtask

   task automatic wait_valid(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!valid8 && c < 400);
      chk("valid_wait", 64'(valid8), 64'(1));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_count8"}, 64'(cnt8), 64'(0));
      chk({tag, "_count4"}, 64'(cnt4), 64'(0));
      chk({tag, "_valid"}, 64'(valid8), 64'(0));
      chk({tag, "_toggle"}, 64'(tog8), 64'(0));
      chk({tag, "_hb"}, 64'(hb8), 64'(0));
      chk({tag, "_period"}, 64'(per8), 64'(0));
   endtask

   initial begin
      int c;
      int nv;
      int exp37;
      int expsat;
      rst_n = 1'b0;
      clear = 1'b0;
      evt   = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      #2 rst_n = 1'b1;

      // 1: ch0 one pulse every 10 clocks, ch1 idle
      nv = 0;
      c  = 0;
      for (int t = 0; t < 300; t++) begin
         evt[0] = (t % 10 == 0);
         @(negedge clk);
         c++;
         if (valid8) begin
            nv++;
            chk("t1_gap", 64'(c), 64'(100));
            c = 0;
            chk("t1_ch0", 64'(cnt8[7:0]), 64'(10));
            chk("t1_ch1", 64'(cnt8[15:8]), 64'(0));
            chk("t1_hb", 64'(hb8), 64'(nv % 2));
         end
      end
      evt[0] = 1'b0;

      // 2: ch2 toggling every clock, counted on falling edges
      nv = 0;
      for (int t = 0; t < 300; t++) begin
         evt[2] = (t % 2 == 1);
         @(negedge clk);
         if (valid8) begin
            nv++;
            if (nv >= 2) begin
               chk("t2_ch2_w8", 64'(cnt8[23:16]), 64'(50));
               chk("t2_ch2_w4", 64'(cnt4[11:8]), 64'(15));
               chk("t2_ch0", 64'(cnt8[7:0]), 64'(0));
            end
         end
      end
      evt[2] = 1'b0;

      // 3: strobe in the terminal cycle, then strobe in cycle 0
      wait_gcnt(97);
      evt[1] = 1'b1;
      wait_valid(c);
      chk("t3_last_cycle", 64'(cnt8[15:8]), 64'(1));
      wait_gcnt(30);
      evt[1] = 1'b0;
      wait_gcnt(98);
      evt[1] = 1'b1;
      wait_valid(c);
      chk("t3_not_in_old", 64'(cnt8[15:8]), 64'(0));
      wait_valid(c);
      chk("t3_in_new", 64'(cnt8[15:8]), 64'(1));
      evt[1] = 1'b0;

      // 4: clear in the terminal cycle
      wait_gcnt(0);
      for (int t = 0; t < 100; t++) begin
         evt[0] = (t % 5 == 0);
         @(negedge clk);
      end
      chk("t4_pre_valid", 64'(valid8), 64'(1));
      chk("t4_pre_ch0", 64'(cnt8[7:0]), 64'(20));
      for (int t = 100; t < 199; t++) begin
         evt[0] = (t % 5 == 0);
         @(negedge clk);
      end
      evt[0] = 1'b0;
      clear  = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("t4_no_valid", 64'(valid8), 64'(0));
      chk("t4_hold_ch0", 64'(cnt8[7:0]), 64'(20));
      c = 0;
      for (int t = 200; t < 600 && !valid8; t++) begin
         evt[0] = (t % 4 == 0);
         @(negedge clk);
         c++;
      end
      chk("t4_gap", 64'(c), 64'(100));
      chk("t4_ch0", 64'(cnt8[7:0]), 64'(25));
      evt[0] = 1'b0;

      // 5: asynchronous reset mid-window
      wait_gcnt(50);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("t5_async");
      repeat (3) @(negedge clk);
      chk_all_zero("t5_held");
      #2 rst_n = 1'b1;
      wait_valid(c);
      chk("t5_gap", 64'(c), 64'(100));
      chk("t5_count", 64'(cnt8), 64'(0));
      chk("t5_hb", 64'(hb8), 64'(1));

      // 6: ch3 edges 37 clocks apart, then a long gap
`ifdef FPS_METER_PERIOD_EN
      exp37  = 37;
      expsat = 4095;
`else
      exp37  = 0;
      expsat = 0;
`endif
      evt[3] = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_first", 64'(per8[47:36]), 64'(0));
      repeat (6) @(negedge clk);
      evt[3] = 1'b0;
      repeat (27) @(negedge clk);
      evt[3] = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_second", 64'(per8[47:36]), 64'(exp37));
      evt[3] = 1'b0;
      repeat (5000) @(negedge clk);
      evt[3] = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_sat", 64'(per8[47:36]), 64'(expsat));
      chk("t6_sat_w4", 64'(per4[47:36]), 64'(expsat));
      evt[3] = 1'b0;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end

endmodule
